// File: rtl/hog_bin_if.sv
// hog_bin_if: pixel-pair input and cell-histogram output handshakes of hog_bin_accum.
interface hog_bin_if #(
    parameter int MAG_W = 9,
    parameter int BIN_W = 15
);
    logic                   in_valid;
    logic                   in_ready;
    logic [19:0]            tan;
    logic [MAG_W-1:0]       mag;
    logic                   out_valid;
    logic                   out_ready;
    logic [9*BIN_W-1:0]     hist;

    modport master (output in_valid, tan, mag, out_ready, input in_ready, out_valid, hist);
    modport slave  (input in_valid, tan, mag, out_ready, output in_ready, out_valid, hist);
endinterface

// File: rtl/hog_bin_accum.sv
// hog_bin_accum: quantises Q4.16 tangents into 9 orientation bins and accumulates magnitude per cell.
// Define HOG_BIN_SAT_EN to make bin additions saturate instead of wrapping.
module hog_bin_accum #(
    parameter int MAG_W    = 9,
    parameter int CELL_PIX = 64,
    parameter int BIN_W    = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    hog_bin_if.slave bus
);
    localparam int CW = $clog2(CELL_PIX);
    localparam logic signed [19:0] T20 = 20'sh05D2D;
    localparam logic signed [19:0] T40 = 20'sh0D6CF;
    localparam logic signed [19:0] T60 = 20'sh1BB68;
    localparam logic signed [19:0] T80 = 20'sh5ABD9;
    localparam logic signed [19:0] N20 = 20'shFA2D3;
    localparam logic signed [19:0] N40 = 20'shF2931;
    localparam logic signed [19:0] N60 = 20'shE4498;
    localparam logic signed [19:0] N80 = 20'shA5427;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [3:0]        s1_bin_q, s1_bin_d, bin_idx;
    logic [MAG_W-1:0]  s1_mag_q, s1_mag_d;
    logic [BIN_W-1:0]  bins_q [9];
    logic [BIN_W-1:0]  bins_d [9];
    logic signed [19:0] t;
    logic              accept, last;

    function automatic logic [BIN_W-1:0] add_bin(input logic [BIN_W-1:0] a, input logic [MAG_W-1:0] m);
        logic [BIN_W:0] s;
        s = {1'b0, a} + (BIN_W+1)'(m);
`ifdef HOG_BIN_SAT_EN
        return s[BIN_W] ? '1 : s[BIN_W-1:0];
`else
        return s[BIN_W-1:0];
`endif
    endfunction

    assign t             = $signed(bus.tan);
    assign bus.in_ready  = state_q == ACCUM;
    assign bus.out_valid = state_q == HOLD;
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = cnt_q == CW'(CELL_PIX - 1);

    // Negative side keeps N80 itself in bin 4 so both divide-by-zero codes share it.
    assign bin_idx = !t[19] ? (t < T20 ? 4'd0 : t < T40 ? 4'd1 : t < T60 ? 4'd2 : t < T80 ? 4'd3 : 4'd4)
                            : (t >= N20 ? 4'd8 : t >= N40 ? 4'd7 : t >= N60 ? 4'd6 : t > N80 ? 4'd5 : 4'd4);

    always_comb begin
        state_d    = state_q;
        cnt_d      = accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        s1_valid_d = accept;
        s1_bin_d   = accept ? bin_idx : s1_bin_q;
        s1_mag_d   = accept ? bus.mag : s1_mag_q;
        s2_valid_d = s1_valid_q;
        bins_d     = bins_q;
        for (int k = 0; k < 9; k++)
            if (s1_valid_q && s1_bin_q == 4'(k)) bins_d[k] = add_bin(bins_q[k], s1_mag_q);
        case (state_q)
            ACCUM:   state_d = accept && last ? DRAIN : ACCUM;
            DRAIN:   state_d = !s1_valid_q && !s2_valid_q ? HOLD : DRAIN;
            HOLD: begin
                state_d = bus.out_ready ? ACCUM : HOLD;
                if (bus.out_ready) bins_d = '{default: '0};
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s1_mag_q   <= '0;
            bins_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_bin_q   <= s1_bin_d;
            s1_mag_q   <= s1_mag_d;
            bins_q     <= bins_d;
        end
    end

    genvar k;
    for (k = 0; k < 9; k++) begin : g_hist
        assign bus.hist[k*BIN_W +: BIN_W] = bins_q[k];
    end
endmodule
